large_memory: RTL and testbench



---
 rtl/large_memory.sv | 158 +++++++++++++++
 tb/tb_large_memory.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/large_memory.sv
// -----------------------------------------------------------------------------
// large_memory
//   Word-organised 32-bit data memory built from synchronous block RAM.
//   The write and read ports each have a request/acknowledge handshake and
//   their own FSM, and the two ports run concurrently. Byte addresses are
//   range-checked. An out-of-range access never touches the array and sets
//   a sticky error flag instead.
//
// Parameters
//   WORDS      number of 32-bit words (valid byte range 0 .. WORDS*4-1)
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous active-high reset (control state only, not array)
//   in_addr    write byte address (word index in_addr[..:2])
//   in_data    write data
//   in_valid   write request, held until in_ready
//   in_ready   write-completion pulse, one cycle
//   out_addr   read byte address
//   out_valid  read request, held until out_ready
//   out_ready  read-completion pulse, one cycle; out_data valid while high
//   out_data   registered read data, held until the next read completes
//   addr_error sticky out-of-range flag, cleared only by reset
// -----------------------------------------------------------------------------
module large_memory #(
  parameter int unsigned WORDS = 655360
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] out_addr,
  input  logic        out_valid,
  output logic        out_ready,
  output logic [31:0] out_data,
  output logic        addr_error
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  // One bit wider than the address so WORDS*4 = 2^32 would still compare.
  localparam logic [32:0] LIMIT = 33'(WORDS) * 33'd4;

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_DONE  = 1'b1;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_WAIT1 = 2'd1;
  localparam logic [1:0] R_WAIT2 = 2'd2;
  localparam logic [1:0] R_DONE  = 2'd3;

  logic [31:0]      mem_q [WORDS];
  logic [31:0]      rd_word_q;

  logic [0:0]       w_state_q, w_state_d;
  logic             in_ready_q, in_ready_d;

  logic [1:0]       r_state_q, r_state_d;
  logic             rd_oor_q, rd_oor_d;
  logic             out_ready_q, out_ready_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             err_q, err_d;

  logic             wr_accept, rd_accept;
  logic             wr_in_range, rd_in_range;
  logic             wr_en, rd_en;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign wr_in_range = {1'b0, in_addr}  < LIMIT;
  assign rd_in_range = {1'b0, out_addr} < LIMIT;
  assign wr_idx      = in_addr[IDX_W+1:2];
  assign rd_idx      = out_addr[IDX_W+1:2];

  assign wr_accept   = (w_state_q == W_IDLE) && in_valid;
  assign rd_accept   = (r_state_q == R_IDLE) && out_valid;

  // Array ports are only enabled for in-range accepted requests; the index
  // of an out-of-range address may lie beyond the array.
  assign wr_en = wr_accept && wr_in_range && !reset;
  assign rd_en = rd_accept && rd_in_range && !reset;

  // NOTE: the array and its read register get no reset so they map onto
  // block RAM; clearing 2.5 MiB on reset is neither wanted nor possible.
  // Non-blocking assignment makes the read see the pre-write contents when
  // both ports hit the same word on the same edge (read-first behaviour).
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= in_data;
    if (rd_en) rd_word_q     <= mem_q[rd_idx];
  end

  // Write FSM: accept, write and pulse in_ready, then one dead cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_d  = w_state_q;
    in_ready_d = 1'b0;
    unique case (w_state_q)
      W_IDLE: if (in_valid) begin
        in_ready_d = 1'b1;
        w_state_d  = W_DONE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: two wait states cover the RAM read and the output register.
  always_comb begin
    r_state_d   = r_state_q;
    rd_oor_d    = rd_oor_q;
    out_ready_d = 1'b0;
    out_data_d  = out_data_q;
    unique case (r_state_q)
      R_IDLE: if (out_valid) begin
        rd_oor_d  = !rd_in_range;
        r_state_d = R_WAIT1;
      end
      R_WAIT1: r_state_d = R_WAIT2;
      R_WAIT2: begin
        out_data_d  = rd_oor_q ? 32'd0 : rd_word_q;
        out_ready_d = 1'b1;
        r_state_d   = R_DONE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // The error flag rises together with the offending access's ready pulse.
  assign err_d = err_q
               | (wr_accept && !wr_in_range)
               | ((r_state_q == R_WAIT2) && rd_oor_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      in_ready_q  <= 1'b0;
      r_state_q   <= R_IDLE;
      rd_oor_q    <= 1'b0;
      out_ready_q <= 1'b0;
      out_data_q  <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      in_ready_q  <= in_ready_d;
      r_state_q   <= r_state_d;
      rd_oor_q    <= rd_oor_d;
      out_ready_q <= out_ready_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_ready  = out_ready_q;
  assign out_data   = out_data_q;
  assign addr_error = err_q;

endmodule

// File: tb/tb_large_memory.sv
// -----------------------------------------------------------------------------
// tb_large_memory
//   Self-checking bench for large_memory. Directed steps cover the handshake
//   timing, range boundaries, the sticky flag, reset and concurrent access;
//   a randomized phase follows. Expected data comes from a sparse word model
//   (associative array) and the flag from a single expected bit.
// -----------------------------------------------------------------------------
module tb_large_memory;

  localparam logic [31:0] LIM = 32'd2621440;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_addr, in_data, out_addr, out_data;
  logic        in_valid, in_ready, out_valid, out_ready, addr_error;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] model [int unsigned];
  logic        exp_err;

  large_memory dut (
    .clk        (clk),
    .reset      (reset),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .addr_error (addr_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected read result for an address, given the model contents now.
  task automatic exp_read(input logic [31:0] a, output bit known, output logic [31:0] d);
    int unsigned idx;
    idx = int'(a >> 2);
    if (a >= LIM)               begin known = 1'b1; d = 32'd0;      end
    else if (model.exists(idx)) begin known = 1'b1; d = model[idx]; end
    else                        begin known = 1'b0; d = 32'd0;      end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (a < LIM) model[int'(a >> 2)] = d;
    else         exp_err = 1'b1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_valid = 1'b0;
    reset     = 1'b1;
    step();
    step();
    reset   = 1'b0;
    exp_err = 1'b0;
    check("rst_in_ready",  in_ready,   0);
    check("rst_out_ready", out_ready,  0);
    check("rst_out_data",  out_data,   0);
    check("rst_err",       addr_error, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    in_addr  = a;
    in_data  = d;
    in_valid = 1'b1;
    step();
    model_write(a, d);
    check("wr_ready", in_ready, 1);
    check("wr_err", addr_error, exp_err);
    in_valid = 1'b0;
    step();
    check("wr_ready_drop", in_ready, 0);
  endtask

  task automatic do_read(input logic [31:0] a);
    bit          known;
    logic [31:0] d;
    logic        prior_err;
    exp_read(a, known, d);
    prior_err = exp_err;
    out_addr  = a;
    out_valid = 1'b1;
    step();
    check("rd_ready_k", out_ready, 0);
    out_valid = 1'b0;
    step();
    check("rd_ready_k1", out_ready, 0);
    check("rd_err_early", addr_error, prior_err);
    step();
    if (a >= LIM) exp_err = 1'b1;
    check("rd_ready", out_ready, 1);
    check("rd_err", addr_error, exp_err);
    if (known) check("rd_data", out_data, d);
    step();
    check("rd_ready_drop", out_ready, 0);
    if (known) check("rd_data_hold", out_data, d);
  endtask

  initial begin
    bit          known;
    logic [31:0] d, a, old200, v;

    in_addr = '0; in_data = '0; in_valid = 1'b0;
    out_addr = '0; out_valid = 1'b0;
    reset = 1'b1;
    exp_err = 1'b0;
    do_reset();

    // Write path, including a request held through the DONE cycle.
    do_write(32'd36, 32'hefefefef);
    do_write(32'd40, 32'hc3c3c3c3);
    in_addr = 32'd44; in_data = 32'h11112222; in_valid = 1'b1;
    step();
    model_write(32'd44, 32'h11112222);
    check("hold_wr_ready1", in_ready, 1);
    in_addr = 32'd32; in_data = 32'h35353535;
    step();
    check("hold_wr_done", in_ready, 0);
    step();
    model_write(32'd32, 32'h35353535);
    check("hold_wr_ready2", in_ready, 1);
    in_valid = 1'b0;
    step();
    check("hold_wr_drop", in_ready, 0);

    // Read path, including a request held through the DONE cycle.
    do_read(32'd40);
    do_read(32'd36);
    out_addr = 32'd36; out_valid = 1'b1;
    step(); step();
    check("hold_rd_wait", out_ready, 0);
    step();
    check("hold_rd_ready1", out_ready, 1);
    check("hold_rd_data1", out_data, 32'hefefefef);
    out_addr = 32'd32;
    step();
    check("hold_rd_done", out_ready, 0);
    step(); step();
    check("hold_rd_wait2", out_ready, 0);
    step();
    check("hold_rd_ready2", out_ready, 1);
    check("hold_rd_data2", out_data, 32'h35353535);
    out_valid = 1'b0;
    step();
    check("hold_rd_drop", out_ready, 0);

    // Write bounds.
    do_reset();
    in_addr = LIM; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wr_idle_invalid_err", addr_error, 0);
    end
    do_write(32'd0, 32'h0badf00d);
    do_write(LIM - 1, 32'h1234abcd);
    do_write(LIM, 32'hdeadbeef);
    do_write(32'h80000024, 32'hdeadbeef);  // aliases word 9 if truncated
    do_read(32'd0);
    do_read(LIM - 4);
    do_read(32'd36);

    // Read bounds.
    do_reset();
    out_addr = LIM; out_valid = 1'b0;
    step();
    check("rd_idle_invalid_err", addr_error, 0);
    do_read(LIM - 1);
    do_read(LIM);

    // Sticky flag survives a valid access; reset clears it, not the array.
    do_write(32'd36, 32'h5a5a5a5a);
    do_read(32'd40);
    do_reset();
    do_read(32'd36);
    do_read(32'd32);

    // Reset during a read aborts it with no completion pulse.
    out_addr = 32'd40; out_valid = 1'b1;
    step();
    out_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_rd_ready", out_ready, 0);
    end
    // Reset right after a committed write: the data stays.
    in_addr = 32'd48; in_data = 32'h77665544; in_valid = 1'b1;
    step();
    model_write(32'd48, 32'h77665544);
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_wr_ready", in_ready, 0);
    do_read(32'd48);

    // Concurrent write to 100 and read of 200.
    do_write(32'd200, 32'h20020020);
    for (int pass = 0; pass < 2; pass++) begin
      a = (pass == 0) ? 32'd100 : 32'd200;
      v = $urandom;
      exp_read(32'd200, known, old200);
      in_addr = a; in_data = v; in_valid = 1'b1;
      out_addr = 32'd200; out_valid = 1'b1;
      step();
      model_write(a, v);
      check("cc_in_ready", in_ready, 1);
      check("cc_out_ready_k", out_ready, 0);
      in_valid = 1'b0; out_valid = 1'b0;
      step();
      check("cc_in_drop", in_ready, 0);
      step();
      check("cc_out_ready", out_ready, 1);
      check("cc_out_data_old", out_data, old200);
      step();
      check("cc_out_drop", out_ready, 0);
      do_read(a);
    end

    // Randomized mix of writes and reads around the used region and bound.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       a = LIM - 32'd8 + 32'($urandom_range(0, 15));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 1) == 0) do_write(a, $urandom);
      else                           do_read(a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
